rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8.sv | 147 ++++++++++++++
 tb/tb_rr_arbiter_8.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with registered one-hot grant
// Optional hold-timeout: define RR_ARBITER_TIMEOUT_EN to force release after MAX_HOLD grant cycles.

module rr_arbiter_8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_sel,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state_q;
   logic [2:0] ptr_q;
   logic [2:0] ptr_d;
   logic [7:0] gnt_q;
   logic [2:0] gnt_sel_q;
   logic       gnt_valid_q;

   logic       pick_found;
   logic [2:0] pick_idx;
   logic [2:0] cand;
   logic       owner_release;
   logic       hold_expired;

`ifdef RR_ARBITER_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_cnt_q;
   logic       timeout_q;

   // The counter holds the number of grant cycles already completed, so the
   // MAX_HOLD-th grant cycle is the one where it equals MAX_HOLD-1.
   always_comb begin
      hold_expired = (hold_cnt_q == HOLD_LAST);
   end

   assign timeout = timeout_q;
`else
   logic unused_max_hold;

   // Grants last until the owner lets go; the hold limit has no effect here.
   always_comb begin
      hold_expired = 1'b0;
   end

   assign unused_max_hold = ^8'(MAX_HOLD);
   assign timeout         = 1'b0;
`endif

   // Rotating-priority scan: first set request starting at ptr, wrapping at 7.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      cand       = ptr_q;
      for (int i = 0; i < 8; i++) begin
         cand = ptr_q + 3'(i);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Owner gives up the resource by pulsing done or dropping its request;
   // the next scan starts just past the released owner.
   always_comb begin
      owner_release = done | ~req[gnt_sel_q];
      ptr_d         = gnt_sel_q + 3'd1;
   end

   // Arbiter FSM with registered grant outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 3'd0;
         gnt_q       <= 8'h00;
         gnt_sel_q   <= 3'd0;
         gnt_valid_q <= 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
         hold_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
`endif
      end else begin
`ifdef RR_ARBITER_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               // done is meaningless without an owner and is ignored here.
               if (pick_found) begin
                  state_q     <= GRANT;
                  gnt_q       <= 8'h01 << pick_idx;
                  gnt_sel_q   <= pick_idx;
                  gnt_valid_q <= 1'b1;
`ifdef RR_ARBITER_TIMEOUT_EN
                  hold_cnt_q  <= 8'd0;
`endif
               end else begin
                  gnt_q       <= 8'h00;
                  gnt_valid_q <= 1'b0;
               end
            end

            GRANT: begin
               // Other requesters are ignored until the owner is released;
               // release always passes through one IDLE cycle.
               if (owner_release || hold_expired) begin
                  state_q     <= IDLE;
                  gnt_q       <= 8'h00;
                  gnt_valid_q <= 1'b0;
                  ptr_q       <= ptr_d;
`ifdef RR_ARBITER_TIMEOUT_EN
                  // A normal release on the expiry cycle is not a timeout.
                  timeout_q   <= ~owner_release;
`endif
               end
`ifdef RR_ARBITER_TIMEOUT_EN
               else begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
`endif
            end

            default: begin
               state_q     <= IDLE;
               gnt_q       <= 8'h00;
               gnt_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign gnt_sel   = gnt_sel_q;
   assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - self-checking bench for rr_arbiter_8 (scoreboard of expected owners)

module tb_rr_arbiter_8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_sel;
   logic       gnt_valid;
   logic       timeout;

   int n_checks;
   int n_fail;
   int exp_q[$];

   rr_arbiter_8 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_sel   (gnt_sel),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
      $fatal(1);
   end

   // Advance one edge, sample 1 time unit later, and check the grant invariants.
   task automatic tick();
      @(posedge clk);
      #1;
      n_checks++;
      if ((gnt_valid !== (|gnt)) || !$onehot0(gnt) ||
          (gnt_valid && (gnt !== (8'h01 << gnt_sel)))) begin
         n_fail++;
         $display("FAIL invariant: gnt=%h gnt_sel=%0d gnt_valid=%b, required one-hot gnt matching gnt_sel and gnt_valid=|gnt",
                  gnt, gnt_sel, gnt_valid);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      req = 8'hFF;
      rst = 1'b1;
      #1;
      n_checks++;
      if (gnt !== 8'h00 || gnt_sel !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: gnt=%h sel=%0d valid=%b timeout=%b, required 00/0/0/0",
                  gnt, gnt_sel, gnt_valid, timeout);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: gnt=%h valid=%b, required 00/0 while rst high", gnt, gnt_valid);
      end
      rst = 1'b0;
      req = 8'h00;
   endtask

   task automatic test_first_grant();
      int e;
      do_reset();
      req = 8'h01;
      exp_q.push_back(0);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== (8'h01 << e) || gnt_sel !== 3'(e) || gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL first_grant: gnt=%h sel=%0d valid=%b, required gnt=%h sel=%0d valid=1",
                  gnt, gnt_sel, gnt_valid, 8'h01 << e, e);
      end
   endtask

   task automatic test_round_robin();
      int e;
      int cyc;
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
      for (int k = 0; k < 9; k++) begin
         cyc = 0;
         do begin
            tick();
            cyc++;
         end while (!gnt_valid && cyc < 10);
         e = exp_q.pop_front();
         n_checks++;
         if (gnt !== (8'h01 << e) || gnt_sel !== 3'(e) || cyc != 1) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: gnt=%h sel=%0d after %0d edges, required gnt=%h sel=%0d after 1 edge",
                     k, gnt, gnt_sel, cyc, 8'h01 << e, e);
         end
         done = 1'b1;
         tick();
         done = 1'b0;
         n_checks++;
         if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_gap[%0d]: gnt=%h valid=%b, required 00/0", k, gnt, gnt_valid);
         end
      end
   endtask

   task automatic test_ptr_wrap();
      int e;
      do_reset();
      req = 8'h10;
      exp_q.push_back(4);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== (8'h01 << e) || gnt_sel !== 3'(e)) begin
         n_fail++;
         $display("FAIL wrap_owner4: gnt=%h sel=%0d, required gnt=%h sel=%0d", gnt, gnt_sel, 8'h01 << e, e);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      // Scan now starts at 5 and wraps past 7, reaching bit 0 before bit 3.
      req = 8'h09;
      exp_q.push_back(0);
      exp_q.push_back(3);
      for (int k = 0; k < 2; k++) begin
         tick();
         e = exp_q.pop_front();
         n_checks++;
         if (gnt !== (8'h01 << e) || gnt_sel !== 3'(e)) begin
            n_fail++;
            $display("FAIL wrap_grant[%0d]: gnt=%h sel=%0d, required gnt=%h sel=%0d",
                     k, gnt, gnt_sel, 8'h01 << e, e);
         end
         done = 1'b1;
         tick();
         done = 1'b0;
      end
   endtask

   task automatic test_hold();
      int e;
      do_reset();
      req = 8'h04;
      exp_q.push_back(2);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== (8'h01 << e) || gnt_sel !== 3'(e)) begin
         n_fail++;
         $display("FAIL hold_start: gnt=%h sel=%0d, required gnt=%h sel=%0d", gnt, gnt_sel, 8'h01 << e, e);
      end
      req = 8'hF4;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++;
         if (gnt !== 8'h04 || gnt_sel !== 3'd2) begin
            n_fail++;
            $display("FAIL hold_keep[%0d]: gnt=%h sel=%0d, required 04/2", k, gnt, gnt_sel);
         end
      end
      req = 8'hF0;
      tick();
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_drop: gnt=%h valid=%b, required 00/0", gnt, gnt_valid);
      end
      exp_q.push_back(4);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== (8'h01 << e) || gnt_sel !== 3'(e)) begin
         n_fail++;
         $display("FAIL hold_next: gnt=%h sel=%0d, required gnt=%h sel=%0d", gnt, gnt_sel, 8'h01 << e, e);
      end
   endtask

   task automatic test_async_reset();
      int e;
      do_reset();
      req = 8'h20;
      exp_q.push_back(5);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== (8'h01 << e) || gnt_sel !== 3'(e)) begin
         n_fail++;
         $display("FAIL areset_pre: gnt=%h sel=%0d, required gnt=%h sel=%0d", gnt, gnt_sel, 8'h01 << e, e);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_sel !== 3'd0) begin
         n_fail++;
         $display("FAIL areset_drop: gnt=%h valid=%b sel=%0d, required 00/0/0 before any edge",
                  gnt, gnt_valid, gnt_sel);
      end
      @(negedge clk);
      rst = 1'b0;
      req = 8'hFF;
      exp_q.push_back(0);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== (8'h01 << e) || gnt_sel !== 3'(e)) begin
         n_fail++;
         $display("FAIL areset_scan: gnt=%h sel=%0d, required gnt=%h sel=%0d", gnt, gnt_sel, 8'h01 << e, e);
      end
   endtask

`ifdef RR_ARBITER_TIMEOUT_EN
   task automatic test_timeout();
      int e;
      do_reset();
      req = 8'h02;
      exp_q.push_back(1);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== (8'h01 << e) || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL to_start: gnt=%h timeout=%b, required gnt=%h timeout=0", gnt, timeout, 8'h01 << e);
      end
      for (int k = 2; k <= 4; k++) begin
         tick();
         n_checks++;
         if (gnt !== 8'h02 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_hold[%0d]: gnt=%h timeout=%b, required 02/0", k, gnt, timeout);
         end
      end
      tick();
      n_checks++;
      if (gnt !== 8'h00 || timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL to_release: gnt=%h timeout=%b, required 00/1", gnt, timeout);
      end
      exp_q.push_back(1);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== (8'h01 << e) || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL to_regrant: gnt=%h timeout=%b, required gnt=%h timeout=0", gnt, timeout, 8'h01 << e);
      end
      // Normal release on the expiry cycle must not flag a timeout.
      repeat (3) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (gnt !== 8'h00 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL to_coincide: gnt=%h timeout=%b, required 00/0", gnt, timeout);
      end
   endtask
`else
   task automatic test_timeout();
      int e;
      do_reset();
      req = 8'h02;
      exp_q.push_back(1);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== (8'h01 << e) || gnt_sel !== 3'(e)) begin
         n_fail++;
         $display("FAIL nto_start: gnt=%h sel=%0d, required gnt=%h sel=%0d", gnt, gnt_sel, 8'h01 << e, e);
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         n_checks++;
         if (gnt !== 8'h02 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL nto_hold[%0d]: gnt=%h timeout=%b, required 02/0", k, gnt, timeout);
         end
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      req      = 8'h00;
      done     = 1'b0;
      test_reset();
      test_first_grant();
      test_round_robin();
      test_ptr_wrap();
      test_hold();
      test_async_reset();
      test_timeout();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
